micro_sequencer: RTL

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_seq_pkg.sv | 30 +++
 rtl/micro_seq_if.sv | 33 +++
 rtl/micro_stack.sv | 52 +++++
 rtl/micro_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro-sequencer: next-address select codes,
// parameter defaults and a small width helper.
package micro_seq_pkg;

  localparam int STATE_W_DEF     = 8;
  localparam int COND_W_DEF      = 4;
  localparam int RESET_ADDR_DEF  = 0;
  localparam int STACK_DEPTH_DEF = 4;

  // Next-address select codes carried in the control-store NSel field.
  // Codes 1010..1111 are unassigned and advance like NS_INC.
  typedef enum logic [3:0] {
    NS_DEC         = 4'b0000,
    NS_RESET       = 4'b0001,
    NS_CR          = 4'b0010,
    NS_INC         = 4'b0011,
    NS_CR_IF       = 4'b0100,
    NS_WAIT        = 4'b0101,
    NS_CR_ELSE_DEC = 4'b0110,
    NS_RESET_IF    = 4'b0111,
    NS_CALL        = 4'b1000,
    NS_RET         = 4'b1001
  } nsel_t;

  // Width of an index able to address n items (never narrower than 1 bit).
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/micro_seq_if.sv
// Control-store / status bundle between the control unit (master) and the
// micro-sequencer (slave).
interface micro_seq_if
  import micro_seq_pkg::*;
#(
  parameter int STATE_W = STATE_W_DEF,
  parameter int COND_W  = COND_W_DEF
);

  localparam int CSEL_W = sel_width(COND_W);

  logic                En;
  logic [3:0]          NSel;
  logic                Inv;
  logic [CSEL_W-1:0]   CondSel;
  logic [COND_W-1:0]   Cond;
  logic [STATE_W-1:0]  CR;
  logic [STATE_W-1:0]  DecAddr;
  logic [STATE_W-1:0]  State;
  logic                Sts;
  logic                StkErr;

  modport master (
    output En, NSel, Inv, CondSel, Cond, CR, DecAddr,
    input  State, Sts, StkErr
  );

  modport slave (
    input  En, NSel, Inv, CondSel, Cond, CR, DecAddr,
    output State, Sts, StkErr
  );

endinterface

// File: rtl/micro_stack.sv
// Return-address LIFO for the micro-sequencer. Only present when the
// MICROSTACK_EN macro is defined; otherwise this file contributes nothing.
`ifdef MICROSTACK_EN
module micro_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  // ptr counts valid entries, so it needs to represent DEPTH itself.
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (ptr == PTR_W'(DEPTH));
  assign empty  = (ptr == '0);
  assign wr_idx = IDX_W'(ptr);
  assign rd_idx = IDX_W'(ptr - PTR_W'(1));
  assign dout   = mem[rd_idx];

  // Entry count: push on a full stack and pop on an empty one are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PTR_W'(1);
    end
  end

  // Storage needs no reset: an empty pointer makes every entry stale anyway.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule
`endif

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: picks the next microaddress from decoder, CR,
// increment, reset address or (optionally) a return stack, qualified by a
// selectable, invertible condition bit.
// Optional feature macro: MICROSTACK_EN (return stack with CALL/RET codes).
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int STATE_W     = STATE_W_DEF,
  parameter int COND_W      = COND_W_DEF,
  parameter int RESET_ADDR  = RESET_ADDR_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input logic        Clk,
  input logic        Reset,
  micro_seq_if.slave bus
);

  localparam logic [STATE_W-1:0] RST_ADDR = STATE_W'(RESET_ADDR);

  // Reject configurations outside the supported ranges at elaboration.
  if (STATE_W < 4 || STATE_W > 12 || COND_W < 1 || COND_W > 16 || STACK_DEPTH < 1) begin : g_param_check
    $error("micro_sequencer: parameter out of supported range");
  end

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] inc_addr;
  logic [STATE_W-1:0] next_addr;
  logic               cond_bit;
  logic               sts;
  nsel_t              sel;

`ifdef MICROSTACK_EN
  logic               push_req;
  logic               pop_req;
  logic               err_set;
  logic               stk_full;
  logic               stk_empty;
  logic [STATE_W-1:0] stk_top;
  logic               err_q;
`endif

  assign inc_addr  = state_q + STATE_W'(1);
  assign sel       = nsel_t'(bus.NSel);
  assign sts       = cond_bit ^ bus.Inv;
  assign bus.Sts   = sts;
  assign bus.State = state_q;

  // Condition mux; an index past the last condition input reads as 0.
  always_comb begin
    cond_bit = 1'b0;
    if (int'(bus.CondSel) < COND_W) begin
      cond_bit = bus.Cond[bus.CondSel];
    end
  end

  // Next-address selection plus stack requests for CALL/RET.
  always_comb begin
    next_addr = inc_addr;
`ifdef MICROSTACK_EN
    push_req  = 1'b0;
    pop_req   = 1'b0;
    err_set   = 1'b0;
`endif
    case (sel)
      NS_DEC:         next_addr = bus.DecAddr;
      NS_RESET:       next_addr = RST_ADDR;
      NS_CR:          next_addr = bus.CR;
      NS_INC:         next_addr = inc_addr;
      NS_CR_IF:       next_addr = sts ? bus.CR : inc_addr;
      NS_WAIT:        next_addr = sts ? inc_addr : state_q;
      NS_CR_ELSE_DEC: next_addr = sts ? bus.CR : bus.DecAddr;
      NS_RESET_IF:    next_addr = sts ? RST_ADDR : inc_addr;
`ifdef MICROSTACK_EN
      NS_CALL: begin
        next_addr = bus.CR;
        if (stk_full) begin
          err_set = 1'b1;
        end else begin
          push_req = 1'b1;
        end
      end
      NS_RET: begin
        if (stk_empty) begin
          next_addr = RST_ADDR;
          err_set   = 1'b1;
        end else begin
          next_addr = stk_top;
          pop_req   = 1'b1;
        end
      end
`endif
      default:        next_addr = inc_addr;
    endcase
  end

  // Microaddress register; En=0 freezes it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RST_ADDR;
    end else if (bus.En) begin
      state_q <= next_addr;
    end
  end

`ifdef MICROSTACK_EN
  micro_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (STATE_W)
  ) u_stack (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push_req && bus.En),
    .pop   (pop_req && bus.En),
    .din   (inc_addr),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Sticky overflow/underflow flag; only Reset clears it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (bus.En && err_set) begin
      err_q <= 1'b1;
    end
  end

  assign bus.StkErr = err_q;
`else
  assign bus.StkErr = 1'b0;
`endif

endmodule
